change_dispenser: RTL and testbench
===================================

# change_dispenser

Change-payout unit for the beverage vending path: accepts a change amount in 50-cent units, checks it against the coin hopper inventory, and ejects coins one at a time toward the hopper. Its coin output uses the same 2-bit encoding as the coin-acceptor input (01 = 50 cent, 10 = 1 Euro). It also keeps per-denomination inventory counts, which refill strobes increment.

## Interface
- CNT_W, 4, width of each inventory counter (saturating)
- AMT_W, 4, width of requested amount, unit = 50 cent
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  change request present
- req_ready  out  1  block idle, request accepted when req_valid && req_ready
- req_amount  in  AMT_W  change to pay, in 50-cent units
- coin_out  out  2  coin to eject: 00 none, 01 = 50 cent, 10 = 1 Euro
- coin_valid  out  1  coin_out valid, held until acknowledged
- coin_ack  in  1  hopper has ejected the coin (handshake: coin_valid && coin_ack)
- refill_50  in  1  one 50-cent coin added to stock
- refill_100  in  1  one 1-Euro coin added to stock
- inv_50  out  CNT_W  current 50-cent stock
- inv_100  out  CNT_W  current 1-Euro stock
- remaining  out  AMT_W  amount still unpaid (50-cent units)
- done  out  1  one-cycle pulse, payout complete
- error  out  1  one-cycle pulse, request infeasible, nothing paid

## Operation
- Reset values: state IDLE, req_ready=1, coin_valid=0, coin_out=00, done=0, error=0, remaining=0, inv_50=0, inv_100=0.
- States and transitions:
  - IDLE: req_ready=1. On accept, latch req_amount into remaining. Amount 0 -> DONE, else -> CHECK.
  - CHECK: feasible iff 2*min(inv_100, remaining/2) + inv_50 >= remaining, evaluated at width max(CNT_W,AMT_W)+2 with no overflow. Feasible -> SELECT, else -> ERROR.
  - SELECT: if remaining >= 2 and inv_100 > 0, register coin 10; otherwise register coin 01. Go to EJECT.
  - EJECT: coin_valid=1, coin_out stable. On coin_ack, decrement the matching inventory by 1 and remaining by 2 (1 Euro) or 1 (50 cent). If the new remaining is 0 -> DONE, else -> SELECT.
  - DONE: done=1 -> IDLE.
  - ERROR: error=1, remaining keeps the requested amount, inventories untouched -> IDLE.
- Because of the greedy choice plus the CHECK gate, the block never runs short mid-payout; refills only increase stock.
- Refill: inventory +1, saturating at 2^CNT_W-1. Refill and ack-decrement on the same counter in the same cycle leave the count unchanged.
- Refills are accepted in every state, including during payout.
- req_valid is ignored while req_ready=0. No queuing.
- coin_ack is ignored unless coin_valid=1.
- coin_out=00 whenever coin_valid=0.
- remaining holds its last value in IDLE (0 after done, the unpaid amount after error).

## Timing
- Cycle n = accept cycle. CHECK in n+1, SELECT in n+2, first coin_valid in n+3.
- Ack sampled in cycle m: next coin_valid in m+2, or done in m+1 if it was the final coin. req_ready=1 again in m+2.
- Zero amount: done in n+1, req_ready in n+2.
- Infeasible request: error in n+2, req_ready in n+3. coin_valid never asserts.
- A zero-wait hopper (coin_ack tied high) gives one coin every 2 cycles.
- rst asserted at any time: all outputs take reset values immediately (asynchronous). An in-flight coin is dropped and stock is cleared.

## Structure
- Package coin_pkg:
  - coin_t enum: COIN_NONE=2'b00, COIN_50=2'b01, COIN_100=2'b10. Shared with the coin-acceptor FSM.
  - dispenser state enum: IDLE, CHECK, SELECT, EJECT, DONE, ERROR.
- Sub-module coin_store: saturating up/down counter with inc, dec, asynchronous rst, and CNT_W parameter. Instantiated twice, once per denomination.
- Top: FSM, remaining register, feasibility arithmetic.

## Test plan
- Refill 3x 1 Euro and 2x 50 cent, then request 5 with coin_ack tied high -> coins 10,10,01, then done; remaining=0, inv_100=1, inv_50=1.
- inv_100=0, inv_50=3, request 3 -> three 01 coins, then done; inv_50=0.
- inv_100=2, inv_50=0, request 3 -> error in n+2, no coin_valid; remaining=3, inventories unchanged.
- Request 0 -> done in n+1, no coin; req_ready back in n+2. A second req_valid held during the busy cycles is not accepted.
- coin_ack held low for 5 cycles -> coin_out/coin_valid stable throughout. refill_100 in the same cycle as the 1-Euro ack -> inv_100 unchanged.
- Stock at 15 plus refill -> stays 15. rst pulsed mid-EJECT -> coin_valid=0 and inventories=0 immediately; req_ready=1 once rst is released.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared coin encoding (also used by the coin-acceptor) and the change
// dispenser state encoding.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_50   = 2'b01,
    COIN_100  = 2'b10
  } coin_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SELECT,
    EJECT,
    DONE,
    ERROR
  } disp_state_t;

endpackage

// File: rtl/coin_store.sv
// Per-denomination coin inventory: saturating up/down counter.
module coin_store #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: checks the request against stock, then ejects coins
// greedily (1 Euro first) one per hopper handshake.
module change_dispenser
  import coin_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  input  logic             refill_50,
  input  logic             refill_100,
  output logic [CNT_W-1:0] inv_50,
  output logic [CNT_W-1:0] inv_100,
  output logic [AMT_W-1:0] remaining,
  output logic             done,
  output logic             error
);

  // Wide enough that 2*min(inv_100, remaining/2) + inv_50 cannot overflow.
  localparam int FW = ((CNT_W > AMT_W) ? CNT_W : AMT_W) + 2;

  disp_state_t      state_q, state_d;
  coin_t            coin_q, coin_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic             req_ready_q, req_ready_d;
  logic             coin_valid_q, coin_valid_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             ack_fire;
  logic             dec_50, dec_100;
  logic [FW-1:0]    rem_w, half_w, inv_50_w, inv_100_w, use_100_w;
  logic             feasible;

  assign ack_fire = coin_valid_q && coin_ack;
  assign dec_50   = ack_fire && (coin_q == COIN_50);
  assign dec_100  = ack_fire && (coin_q == COIN_100);

  coin_store #(.CNT_W(CNT_W)) u_store_50 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill_50),
    .dec   (dec_50),
    .count (inv_50)
  );

  coin_store #(.CNT_W(CNT_W)) u_store_100 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill_100),
    .dec   (dec_100),
    .count (inv_100)
  );

  always_comb begin
    rem_w     = FW'(remaining_q);
    half_w    = rem_w >> 1;
    inv_50_w  = FW'(inv_50);
    inv_100_w = FW'(inv_100);
    use_100_w = (inv_100_w < half_w) ? inv_100_w : half_w;
    feasible  = ((use_100_w << 1) + inv_50_w) >= rem_w;
  end

  always_comb begin
    state_d     = state_q;
    coin_d      = coin_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          remaining_d = req_amount;
          state_d     = (req_amount == '0) ? DONE : CHECK;
        end
      end
      CHECK:  state_d = feasible ? SELECT : ERROR;
      SELECT: begin
        coin_d  = (remaining_q >= AMT_W'(2) && inv_100 != '0) ? COIN_100 : COIN_50;
        state_d = EJECT;
      end
      EJECT: begin
        if (coin_ack) begin
          remaining_d = remaining_q - ((coin_q == COIN_100) ? AMT_W'(2) : AMT_W'(1));
          coin_d      = COIN_NONE;
          state_d     = (remaining_d == '0) ? DONE : SELECT;
        end
      end
      DONE, ERROR: state_d = IDLE;
      default: begin
        state_d = IDLE;
        coin_d  = COIN_NONE;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    req_ready_d  = (state_d == IDLE);
    coin_valid_d = (state_d == EJECT);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      coin_q       <= COIN_NONE;
      remaining_q  <= '0;
      req_ready_q  <= 1'b1;
      coin_valid_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      coin_q       <= coin_d;
      remaining_q  <= remaining_d;
      req_ready_q  <= req_ready_d;
      coin_valid_q <= coin_valid_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign coin_out   = coin_q;
  assign coin_valid = coin_valid_q;
  assign remaining  = remaining_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// requests checked against a greedy payout model.
module tb_change_dispenser;

  localparam int CNT_W   = 4;
  localparam int AMT_W   = 4;
  localparam int INV_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount;
  logic [1:0]       coin_out;
  logic             coin_valid;
  logic             coin_ack;
  logic             refill_50;
  logic             refill_100;
  logic [CNT_W-1:0] inv_50;
  logic [CNT_W-1:0] inv_100;
  logic [AMT_W-1:0] remaining;
  logic             done;
  logic             error;

  int n_tests = 0;
  int n_fail  = 0;
  int m_inv50  = 0;
  int m_inv100 = 0;

  change_dispenser #(.CNT_W(CNT_W), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_amount (req_amount),
    .coin_out   (coin_out),
    .coin_valid (coin_valid),
    .coin_ack   (coin_ack),
    .refill_50  (refill_50),
    .refill_100 (refill_100),
    .inv_50     (inv_50),
    .inv_100    (inv_100),
    .remaining  (remaining),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v < INV_MAX) ? v + 1 : INV_MAX;
  endfunction

  task automatic check_inventory(input string tag);
    n_tests++;
    if (inv_50 !== 4'(m_inv50) || inv_100 !== 4'(m_inv100)) begin
      n_fail++;
      $display("FAIL %s inventory: got inv_50=%0d inv_100=%0d, expected inv_50=%0d inv_100=%0d",
               tag, inv_50, inv_100, m_inv50, m_inv100);
    end
  endtask

  task automatic do_refill(input int n50, input int n100);
    int k;
    k = (n50 > n100) ? n50 : n100;
    for (int i = 0; i < k; i++) begin
      refill_50  = (i < n50);
      refill_100 = (i < n100);
      step();
      if (i < n50)  m_inv50  = sat_inc(m_inv50);
      if (i < n100) m_inv100 = sat_inc(m_inv100);
    end
    refill_50  = 1'b0;
    refill_100 = 1'b0;
    check_inventory("refill");
  endtask

  // Drives one request and follows it to completion. hold < 0 picks a random
  // ack delay per coin; noise keeps req_valid asserted while the block is busy.
  task automatic run_request(input int amt, input bit ack_high, input int hold,
                             input bit refill_on_ack, input bit noise);
    int         n100, rest, paid, w;
    bit         feasible;
    logic [1:0] exp_q[$];
    logic [1:0] c;

    n100     = (m_inv100 < amt / 2) ? m_inv100 : amt / 2;
    rest     = amt - 2 * n100;
    feasible = (rest <= m_inv50);
    if (feasible) begin
      repeat (n100) exp_q.push_back(2'b10);
      repeat (rest) exp_q.push_back(2'b01);
    end

    coin_ack   = ack_high;
    req_valid  = 1'b1;
    req_amount = 4'(amt);
    step();
    req_valid  = noise;
    req_amount = 4'($urandom_range(0, 15));

    if (amt == 0) begin
      n_tests++;
      if (done !== 1'b1 || coin_valid !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_done: got done=%b coin_valid=%b req_ready=%b, expected 1 0 0",
                 done, coin_valid, req_ready);
      end
      step();
      req_valid = 1'b0;
      n_tests++;
      if (req_ready !== 1'b1 || done !== 1'b0 || remaining !== 4'd0) begin
        n_fail++;
        $display("FAIL zero_ready: got req_ready=%b done=%b remaining=%0d, expected 1 0 0",
                 req_ready, done, remaining);
      end
    end else begin
      n_tests++;
      if (req_ready !== 1'b0 || coin_valid !== 1'b0 || remaining !== 4'(amt)) begin
        n_fail++;
        $display("FAIL check_cycle: got req_ready=%b coin_valid=%b remaining=%0d, expected 0 0 %0d",
                 req_ready, coin_valid, remaining, amt);
      end
      step();
      if (!feasible) begin
        n_tests++;
        if (error !== 1'b1 || coin_valid !== 1'b0 || remaining !== 4'(amt)) begin
          n_fail++;
          $display("FAIL error_pulse: got error=%b coin_valid=%b remaining=%0d, expected 1 0 %0d",
                   error, coin_valid, remaining, amt);
        end
        step();
        req_valid = 1'b0;
        n_tests++;
        if (req_ready !== 1'b1 || error !== 1'b0 || coin_valid !== 1'b0 || remaining !== 4'(amt)) begin
          n_fail++;
          $display("FAIL error_idle: got req_ready=%b error=%b coin_valid=%b remaining=%0d, expected 1 0 0 %0d",
                   req_ready, error, coin_valid, remaining, amt);
        end
      end else begin
        n_tests++;
        if (error !== 1'b0 || coin_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL select_cycle: got error=%b coin_valid=%b, expected 0 0", error, coin_valid);
        end
        step();
        paid = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
          c = exp_q[k];
          n_tests++;
          if (coin_valid !== 1'b1 || coin_out !== c) begin
            n_fail++;
            $display("FAIL coin%0d: got coin_valid=%b coin_out=%b, expected 1 %b",
                     k, coin_valid, coin_out, c);
          end
          w = ack_high ? 0 : ((hold < 0) ? int'($urandom_range(0, 3)) : hold);
          for (int i = 0; i < w; i++) begin
            coin_ack = 1'b0;
            step();
            n_tests++;
            if (coin_valid !== 1'b1 || coin_out !== c || remaining !== 4'(amt - paid)) begin
              n_fail++;
              $display("FAIL coin%0d_hold: got coin_valid=%b coin_out=%b remaining=%0d, expected 1 %b %0d",
                       k, coin_valid, coin_out, remaining, c, amt - paid);
            end
          end
          coin_ack   = 1'b1;
          refill_100 = refill_on_ack;
          step();
          coin_ack   = ack_high;
          refill_100 = 1'b0;
          if (c == 2'b10) begin
            paid += 2;
            if (!refill_on_ack) m_inv100--;
          end else begin
            paid += 1;
            m_inv50--;
            if (refill_on_ack) m_inv100 = sat_inc(m_inv100);
          end
          if (k == exp_q.size() - 1) begin
            n_tests++;
            if (done !== 1'b1 || coin_valid !== 1'b0 || coin_out !== 2'b00 || remaining !== 4'd0) begin
              n_fail++;
              $display("FAIL payout_done: got done=%b coin_valid=%b coin_out=%b remaining=%0d, expected 1 0 00 0",
                       done, coin_valid, coin_out, remaining);
            end
            step();
            req_valid = 1'b0;
            n_tests++;
            if (req_ready !== 1'b1 || done !== 1'b0 || remaining !== 4'd0) begin
              n_fail++;
              $display("FAIL payout_idle: got req_ready=%b done=%b remaining=%0d, expected 1 0 0",
                       req_ready, done, remaining);
            end
          end else begin
            n_tests++;
            if (coin_valid !== 1'b0 || coin_out !== 2'b00 || done !== 1'b0 || remaining !== 4'(amt - paid)) begin
              n_fail++;
              $display("FAIL between_coins: got coin_valid=%b coin_out=%b done=%b remaining=%0d, expected 0 00 0 %0d",
                       coin_valid, coin_out, done, remaining, amt - paid);
            end
            step();
          end
        end
      end
    end
    coin_ack  = 1'b0;
    req_valid = 1'b0;
    check_inventory("request");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    n_tests++;
    if (req_ready !== 1'b1 || coin_valid !== 1'b0 || coin_out !== 2'b00 || done !== 1'b0 ||
        error !== 1'b0 || remaining !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b cv=%b coin=%b done=%b err=%b rem=%0d, expected 1 0 00 0 0 0",
               req_ready, coin_valid, coin_out, done, error, remaining);
    end
    check_inventory("reset");
  endtask

  task automatic test_greedy_tied_high();
    do_refill(2, 3);
    run_request(5, 1'b1, 0, 1'b0, 1'b0);
    n_tests++;
    if (inv_100 !== 4'd1 || inv_50 !== 4'd1) begin
      n_fail++;
      $display("FAIL greedy_stock: got inv_100=%0d inv_50=%0d, expected 1 1", inv_100, inv_50);
    end
  endtask

  task automatic test_only_50();
    run_request(2, 1'b0, 1, 1'b0, 1'b0);
    do_refill(2, 0);
    run_request(3, 1'b0, 0, 1'b0, 1'b1);
    n_tests++;
    if (inv_50 !== 4'd0) begin
      n_fail++;
      $display("FAIL only_50_stock: got inv_50=%0d, expected 0", inv_50);
    end
  endtask

  task automatic test_infeasible();
    do_refill(0, 2);
    run_request(3, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_hold_and_refill();
    run_request(2, 1'b0, 5, 1'b1, 1'b0);
    n_tests++;
    if (inv_100 !== 4'd2) begin
      n_fail++;
      $display("FAIL ack_refill_same_cycle: got inv_100=%0d, expected 2", inv_100);
    end
  endtask

  task automatic test_zero();
    run_request(0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    do_refill(16, 16);
    n_tests++;
    if (inv_100 !== 4'd15 || inv_50 !== 4'd15) begin
      n_fail++;
      $display("FAIL saturation: got inv_100=%0d inv_50=%0d, expected 15 15", inv_100, inv_50);
    end
  endtask

  task automatic test_random();
    int amt, cap;
    run_request(15, 1'b1, 0, 1'b0, 1'b1);
    for (int it = 0; it < 25; it++) begin
      do_refill($urandom_range(0, 3), $urandom_range(0, 3));
      cap = 2 * m_inv100 + m_inv50 + 2;
      if (cap > 15) cap = 15;
      amt = $urandom_range(0, cap);
      run_request(amt, 1'($urandom_range(0, 1)), -1, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_eject();
    do_refill(0, 1);
    req_valid  = 1'b1;
    req_amount = 4'd2;
    step();
    req_valid = 1'b0;
    repeat (2) step();
    n_tests++;
    if (coin_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_eject: got coin_valid=%b, expected 1", coin_valid);
    end
    rst = 1'b1;
    #1;
    m_inv50  = 0;
    m_inv100 = 0;
    n_tests++;
    if (coin_valid !== 1'b0 || coin_out !== 2'b00 || req_ready !== 1'b1 || remaining !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: got coin_valid=%b coin_out=%b req_ready=%b remaining=%0d, expected 0 00 1 0",
               coin_valid, coin_out, req_ready, remaining);
    end
    check_inventory("async_reset");
    step();
    rst = 1'b0;
    step();
    n_tests++;
    if (req_ready !== 1'b1 || coin_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got req_ready=%b coin_valid=%b, expected 1 0", req_ready, coin_valid);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_amount = '0;
    coin_ack   = 1'b0;
    refill_50  = 1'b0;
    refill_100 = 1'b0;
    test_reset();
    test_greedy_tied_high();
    test_only_50();
    test_infeasible();
    test_hold_and_refill();
    test_zero();
    test_saturation();
    test_random();
    test_reset_mid_eject();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
